// File: rtl/pass_monitor_if.sv
// pass_monitor_if: run-control and result bundle between a test controller and pass_monitor
interface pass_monitor_if #(
    parameter int NCHK = 4
);
    logic            start;
    logic            stop;
    logic [NCHK-1:0] pass_in;
    logic            done;
    logic            pass;
    logic            short_run;
    logic [NCHK-1:0] fail_mask;
    logic [7:0]      edge_count;

    modport master (
        output start, stop, pass_in,
        input  done, pass, short_run, fail_mask, edge_count
    );

    modport slave (
        input  start, stop, pass_in,
        output done, pass, short_run, fail_mask, edge_count
    );
endinterface

// File: rtl/pass_monitor.sv
// pass_monitor: times a run of the monitored instances and folds their pass flags into a registered verdict (optional PASS_MONITOR_DISPLAY_EN prints it)
module pass_monitor #(
    parameter int          NCHK      = 4,
    parameter int unsigned MIN_EDGES = 8
) (
    input  logic          clk,
    input  logic          rst,
    pass_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            short_run_q, short_run_d;
    logic [NCHK-1:0] fail_mask_q, fail_mask_d;
    logic [7:0]      edge_count_q, edge_count_d;
    logic [NCHK-1:0] fail_now;
    logic [NCHK-1:0] fail_mask_run;
    logic [7:0]      edge_count_run;
    logic            short_run_run;
    logic            restart;

    // Anything other than a solid 1 on a pass flag (0, X or Z) counts as a failure
    always_comb begin
        fail_now = '0;
        for (int i = 0; i < NCHK; i++) fail_now[i] = (bus.pass_in[i] !== 1'b1);
    end

    // Totals as they stand once the current RUN cycle is included
    always_comb begin
        edge_count_run = (edge_count_q == 8'hFF) ? edge_count_q : edge_count_q + 8'd1;
        fail_mask_run  = fail_mask_q | fail_now;
        short_run_run  = 32'(edge_count_run) < MIN_EDGES;
        restart        = (state_q != RUN) && bus.start;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: start opens a run from IDLE or DONE, stop closes it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = bus.stop  ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Result updates: clear on a new run, accumulate in RUN, latch the verdict on stop
    always_comb begin
        done_d       = done_q;
        pass_d       = pass_q;
        short_run_d  = short_run_q;
        fail_mask_d  = fail_mask_q;
        edge_count_d = edge_count_q;
        if (restart) begin
            done_d       = 1'b0;
            pass_d       = 1'b0;
            short_run_d  = 1'b0;
            fail_mask_d  = '0;
            edge_count_d = '0;
        end else if (state_q == RUN) begin
            fail_mask_d  = fail_mask_run;
            edge_count_d = edge_count_run;
            if (bus.stop) begin
                done_d      = 1'b1;
                short_run_d = short_run_run;
                pass_d      = (fail_mask_run == '0) && !short_run_run;
            end
        end
    end

    // Result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            short_run_q  <= 1'b0;
            fail_mask_q  <= '0;
            edge_count_q <= '0;
        end else begin
            done_q       <= done_d;
            pass_q       <= pass_d;
            short_run_q  <= short_run_d;
            fail_mask_q  <= fail_mask_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.short_run  = short_run_q;
    assign bus.fail_mask  = fail_mask_q;
    assign bus.edge_count = edge_count_q;

`ifdef PASS_MONITOR_DISPLAY_EN
    // Announce the verdict on the edge that moves the run into DONE
    always @(posedge clk) begin
        if (!rst && state_q == RUN && bus.stop) begin
            if (pass_d) $display("%t: PASSED", $time);
            else        $display("%t: FAILED mask=%b count=%0d", $time, fail_mask_d, edge_count_d);
        end
    end
`else
`endif
endmodule

// File: doc/pass_monitor.md
PASS_MONITOR -- requirements
Module: pass_monitor

Interface
REQ-001 Parameter NCHK, default 4: number of per-instance pass flags monitored.
REQ-002 Parameter MIN_EDGES, default 8: minimum RUN cycles for a valid run.
REQ-003 clk  input  1  rising-edge clock, shared with the monitored sub-instances.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  begin a run; sampled on posedge clk.
REQ-006 stop  input  1  end the run; sampled on posedge clk.
REQ-007 pass_in  input  NCHK  pass flags driven by the downstream-checked instances.
REQ-008 done  output  1  run complete; result outputs valid.
REQ-009 pass  output  1  overall verdict, valid while done=1.
REQ-010 short_run  output  1  run ended with fewer than MIN_EDGES RUN cycles.
REQ-011 fail_mask  output  NCHK  sticky per-instance failure bits.
REQ-012 edge_count  output  8  RUN cycles counted.
REQ-013 Clocking fixed: one clock (clk); reset rst is synchronous, active-high.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> RUN next cycle; edge_count and fail_mask cleared to 0.
REQ-016 RUN: each cycle edge_count increments by 1, saturating at 255 (no wrap).
REQ-017 RUN: each cycle, fail_mask[i] sets if pass_in[i] is not exactly 1'b1 (0, X, Z all fail; case-equality compare).
REQ-018 fail_mask bits are sticky for the run; cleared only by reset or a new start.
REQ-019 RUN with stop=1: that cycle still counts and samples pass_in; state -> DONE.
REQ-020 On entry to DONE: done=1; short_run=(edge_count<MIN_EDGES); pass=(fail_mask==0)&&!short_run, all using values including the stop cycle.
REQ-021 DONE: all outputs hold; start=1 -> RUN, done/pass/short_run cleared, counters cleared as in REQ-015.
REQ-022 start ignored in RUN; stop ignored in IDLE and DONE.
REQ-023 start=1 and stop=1 together in IDLE: start wins, stop ignored.
REQ-024 pass=0 whenever done=0.
REQ-025 Latency: stop sampled at edge N -> done=1 visible after edge N.

Reset
REQ-026 rst=1 at posedge clk SHALL force IDLE, done=0, pass=0, short_run=0, fail_mask=0, edge_count=0.
REQ-027 Reset SHALL take priority over start/stop in any state, including mid-RUN.
REQ-028 Before the first posedge clk outputs are undefined; no action occurs at time zero without a clock edge.

Configuration
REQ-029 Macro PASS_MONITOR_DISPLAY_EN: when defined, on each DONE entry the block SHALL $display "%t: PASSED" or "%t: FAILED mask=%b count=%0d" using $time, fail_mask, edge_count.
REQ-030 Without PASS_MONITOR_DISPLAY_EN: no display calls; registered behaviour identical.

Verification
REQ-031 Reset, start, pass_in=4'b1111, stop on 10th RUN cycle -> done=1, pass=1, edge_count=10, short_run=0, fail_mask=0.
REQ-032 As REQ-031 but pass_in[2]=0 for one cycle at RUN cycle 4 -> fail_mask=4'b0100, pass=0, short_run=0.
REQ-033 stop on 5th RUN cycle, all passing -> short_run=1, pass=0, edge_count=5.
REQ-034 300-cycle run, all passing -> edge_count=255 (saturated), pass=1.
REQ-035 rst=1 at RUN cycle 6 -> next cycle all outputs zero, state IDLE; subsequent stop has no effect; done stays 0.
REQ-036 pass_in[0]=1'bx for one RUN cycle -> fail_mask[0]=1, pass=0.
